// File: rtl/clk_gen_pkg.sv
// Shared types for the multi-channel clock generator: channel FSM states,
// per-channel timing configuration and the high-time sanitiser.
package clk_gen_pkg;

    // Storage width of every timing field; CNT_W on the top must not exceed it.
    localparam int CFG_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } chan_cfg_t;

    // A high time of P or more means "always high", so clamp it to P.
    function automatic logic [CFG_W-1:0] eff_high(input logic [CFG_W-1:0] high,
                                                   input logic [CFG_W-1:0] period);
        return (high > period) ? period : high;
    endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One generator channel: double-buffered config, start/phase handling and the
// IDLE/PHASE/HIGH/LOW sequencer producing registered clk_out and cyc_start.
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int DEF_PERIOD = 4,
    parameter int DEF_HIGH   = 2,
    parameter int DEF_PHASE  = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      sync_start,
    input  logic      wr,
    input  chan_cfg_t wr_cfg,
    output logic      clk_out,
    output logic      cyc_start,
    output logic      pending
);

    localparam chan_cfg_t DEF_CFG = '{
        period: CFG_W'(DEF_PERIOD),
        high:   CFG_W'(DEF_HIGH),
        phase:  CFG_W'(DEF_PHASE)
    };

    chan_state_e      state, state_d;
    chan_cfg_t        shadow, active, active_d, use_cfg;
    logic [CFG_W-1:0] cnt, cnt_d, cnt_inc, h_act, h_use;
    logic             en_q, start, new_period;
    logic             clk_d, cyc_d, pend_d;

    // Config that the next period will run with: shadow wins while pending.
    assign use_cfg = pending ? shadow : active;
    assign h_act   = eff_high(active.high, active.period);
    assign h_use   = eff_high(use_cfg.high, use_cfg.period);
    assign cnt_inc = cnt + 1'b1;
    assign start   = en && (!en_q || sync_start);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        active_d   = active;
        clk_d      = clk_out;
        cyc_d      = 1'b0;
        pend_d     = pending;
        new_period = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
        end else if (start) begin
            state_d  = PHASE;
            cnt_d    = '0;
            clk_d    = 1'b0;
            active_d = shadow;
            pend_d   = 1'b0;
        end else begin
            unique case (state)
                IDLE: clk_d = 1'b0;
                PHASE: begin
                    if (cnt == active.phase) new_period = 1'b1;
                    else                     cnt_d = cnt_inc;
                end
                HIGH, LOW: begin
                    if (cnt == active.period - 1'b1) begin
                        new_period = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                        clk_d   = (cnt_inc < h_act);
                        state_d = clk_d ? HIGH : LOW;
                    end
                end
            endcase

            if (new_period) begin
                active_d = use_cfg;
                pend_d   = 1'b0;
                cnt_d    = '0;
                cyc_d    = 1'b1;
                clk_d    = (h_use != '0);
                state_d  = clk_d ? HIGH : LOW;
            end
        end

        // A write on a boundary edge still leaves the new shadow pending.
        if (wr) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            active    <= DEF_CFG;
            shadow    <= DEF_CFG;
            pending   <= 1'b0;
            clk_out   <= 1'b0;
            cyc_start <= 1'b0;
            en_q      <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            active    <= active_d;
            pending   <= pend_d;
            clk_out   <= clk_d;
            cyc_start <= cyc_d;
            en_q      <= en;
            if (wr) shadow <= wr_cfg;
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock/pulse generator: config write decode,
// reject reporting and NUM_CH independent channel instances.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int CNT_W      = 16,
    parameter  int DEF_PERIOD = 4,
    parameter  int DEF_HIGH   = 2,
    parameter  int DEF_PHASE  = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_start,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] cyc_start
);

    // cfg_valid is a one-cycle strobe with no ready: a write is either
    // accepted into the target shadow that edge or rejected with cfg_err
    // one cycle later; there is no back-pressure.
    chan_cfg_t wr_cfg;
    logic      ch_ok, cfg_ok;

    assign wr_cfg = '{
        period: CFG_W'(cfg_period),
        high:   CFG_W'(cfg_high),
        phase:  CFG_W'(cfg_phase)
    };
    assign ch_ok  = 32'(cfg_ch) < 32'(NUM_CH);
    assign cfg_ok = ch_ok && (cfg_period != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= cfg_valid && !cfg_ok;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_valid && cfg_ok && (32'(cfg_ch) == i);

        clk_gen_chan #(
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH),
            .DEF_PHASE  (DEF_PHASE)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en[i]),
            .sync_start (sync_start),
            .wr         (wr),
            .wr_cfg     (wr_cfg),
            .clk_out    (clk_out[i]),
            .cyc_start  (cyc_start[i]),
            .pending    (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed bench for clk_gen_multi: the driver pushes hand-computed expected
// output vectors, a monitor pops and compares them after every clock edge.
module tb_clk_gen_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;
    localparam logic [19:0] ALL_ZERO = 20'hFFC00;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync_start;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period, cfg_high, cfg_phase;
    logic              cfg_err;
    logic [NUM_CH-1:0] cfg_pending, clk_out, cyc_start;

    int checks = 0;
    int errors = 0;

    // Entry layout: [19:10] care mask, [9:0] value; each half is
    // {cfg_err, cfg_pending[2:0], cyc_start[2:0], clk_out[2:0]}.
    logic [19:0] exp_q[$];
    string       tag_q[$];
    string       cur_test;

    clk_gen_multi #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (4),
        .DEF_HIGH   (2),
        .DEF_PHASE  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync_start  (sync_start),
        .cfg_valid   (cfg_valid),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_phase   (cfg_phase),
        .cfg_err     (cfg_err),
        .cfg_pending (cfg_pending),
        .clk_out     (clk_out),
        .cyc_start   (cyc_start)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // expected-vector builders
    function automatic logic [19:0] e_ch(input int ch, input logic c, input logic s);
        logic [19:0] e;
        e          = '0;
        e[10 + ch] = 1'b1;
        e[13 + ch] = 1'b1;
        e[ch]      = c;
        e[3 + ch]  = s;
        return e;
    endfunction

    function automatic logic [19:0] e_pend(input int ch, input logic p);
        logic [19:0] e;
        e          = '0;
        e[16 + ch] = 1'b1;
        e[6 + ch]  = p;
        return e;
    endfunction

    function automatic logic [19:0] e_err(input logic x);
        logic [19:0] e;
        e     = '0;
        e[19] = 1'b1;
        e[9]  = x;
        return e;
    endfunction

    // driver tasks
    task automatic step(input logic [19:0] e);
        exp_q.push_back(e);
        tag_q.push_back(cur_test);
        @(negedge clk);
    endtask

    task automatic run1(input int ch, input int p, input int h, input int t0, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = t0 + i;
            step(e_ch(ch, (t % p) < h, (t % p) == 0) | e_err(1'b0));
        end
    endtask

    task automatic cfg_wr(input int ch, input int p, input int h, input int ph,
                          input logic [19:0] e);
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        cfg_phase  = CNT_W'(ph);
        step(e);
        cfg_valid  = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [9:0] got, input logic [9:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            logic [9:0]  got;
            string       t;
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {cfg_err, cfg_pending, cyc_start, clk_out} & e[19:10];
            checks++;
            if (got !== e[9:0]) begin
                errors++;
                $display("FAIL %s @%0t: got %b required %b (mask %b)",
                         t, $time, got, e[9:0], e[19:10]);
            end
        end
    end

    // stimulus
    initial begin
        logic [19:0] e;
        logic [19:0] pend0s;
        pend0s     = e_pend(0, 1'b0) | e_pend(1, 1'b0) | e_pend(2, 1'b0);
        rst        = 1'b1;
        en         = '0;
        sync_start = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_phase  = '0;

        cur_test = "reset";
        @(negedge clk);
        step(ALL_ZERO);
        step(ALL_ZERO);
        rst = 1'b0;
        step(ALL_ZERO);

        cur_test = "t1_default";
        en[0] = 1'b1;
        step(e_ch(0, 1'b0, 1'b0) | e_pend(0, 1'b0) | e_err(1'b0));
        run1(0, 4, 2, 0, 13);

        cur_test = "t3_reconfig";
        cfg_wr(0, 6, 1, 0, e_ch(0, 1'b1, 1'b0) | e_pend(0, 1'b1) | e_err(1'b0));
        step(e_ch(0, 1'b0, 1'b0) | e_pend(0, 1'b1));
        step(e_ch(0, 1'b0, 1'b0) | e_pend(0, 1'b1));
        step(e_ch(0, 1'b1, 1'b1) | e_pend(0, 1'b0));
        run1(0, 6, 1, 1, 12);

        cur_test = "t2_phase";
        cfg_wr(1, 10, 5, 7, e_pend(1, 1'b1) | e_err(1'b0));
        en[1] = 1'b1;
        step(e_ch(1, 1'b0, 1'b0) | e_pend(1, 1'b0));
        repeat (7) step(e_ch(1, 1'b0, 1'b0));
        run1(1, 10, 5, 0, 25);

        cur_test = "t4_high0";
        cfg_wr(2, 5, 0, 0, e_pend(2, 1'b1) | e_err(1'b0));
        en[2] = 1'b1;
        step(e_ch(2, 1'b0, 1'b0) | e_pend(2, 1'b0));
        run1(2, 5, 0, 0, 10);

        cur_test = "t4_high_ge_period";
        cfg_wr(2, 10, 12, 0, e_ch(2, 1'b0, 1'b1) | e_pend(2, 1'b1));
        repeat (4) step(e_ch(2, 1'b0, 1'b0) | e_pend(2, 1'b1));
        step(e_ch(2, 1'b1, 1'b1) | e_pend(2, 1'b0));
        run1(2, 10, 12, 1, 14);

        cur_test = "t5_reject";
        cfg_wr(1, 0, 3, 2, e_err(1'b1) | pend0s);
        step(e_err(1'b0) | pend0s);
        cfg_wr(3, 8, 3, 2, e_err(1'b1) | pend0s);
        step(e_err(1'b0) | pend0s);

        cur_test = "t5_shadow_kept";
        en[1] = 1'b0;
        step(e_ch(1, 1'b0, 1'b0));
        en[1] = 1'b1;
        step(e_ch(1, 1'b0, 1'b0) | e_pend(1, 1'b0));
        repeat (7) step(e_ch(1, 1'b0, 1'b0));
        run1(1, 10, 5, 0, 12);

        cur_test = "t6_sync";
        en[2] = 1'b0;
        cfg_wr(0, 4, 2, 3, e_pend(0, 1'b1));
        cfg_wr(1, 4, 2, 0, e_pend(1, 1'b1));
        sync_start = 1'b1;
        step(e_ch(0, 1'b0, 1'b0) | e_ch(1, 1'b0, 1'b0) | e_pend(0, 1'b0) | e_pend(1, 1'b0));
        sync_start = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            e = e_ch(1, ((j - 1) % 4) < 2, ((j - 1) % 4) == 0);
            if (j < 4) e = e | e_ch(0, 1'b0, 1'b0);
            else       e = e | e_ch(0, ((j - 4) % 4) < 2, ((j - 4) % 4) == 0);
            step(e);
        end

        cur_test = "t6_async_rst";
        rst = 1'b1;
        #1;
        check_now("async_rst", {cfg_err, cfg_pending, cyc_start, clk_out}, 10'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(ALL_ZERO);
        en[0] = 1'b0;
        step(e_ch(0, 1'b0, 1'b0));
        en[0] = 1'b1;
        step(e_ch(0, 1'b0, 1'b0) | e_pend(0, 1'b0));
        run1(0, 4, 2, 0, 8);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Synthesizable, parametrised multi-channel clock/pulse generator driven from one reference clock.
- Each channel has programmable period, high time (duty) and start phase, all counted in reference-clock cycles.
- Supersedes behavioural bench-only clock tasks; usable in RTL and as a bench stimulus source.
- Per-channel configuration is double-buffered, so reprogramming is glitch-free and takes effect only at period boundaries.

Parameters:
- NUM_CH, 4: number of independent output channels (1..16).
- CNT_W, 16: width of the period, high and phase counters and config fields.
- DEF_PERIOD, 4: reset value of every channel's period.
- DEF_HIGH, 2: reset value of every channel's high time.
- DEF_PHASE, 0: reset value of every channel's phase offset.

Ports:
- clk  in  1  reference clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable (level).
- sync_start  in  1  single-cycle pulse; restarts all enabled channels together.
- cfg_valid  in  1  single-cycle config write strobe.
- cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH)).
- cfg_period  in  CNT_W  period in cycles.
- cfg_high  in  CNT_W  high cycles per period.
- cfg_phase  in  CNT_W  cycles from start to the first rising edge, minus 1.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- cfg_pending  out  NUM_CH  shadow config is waiting for a period boundary.
- clk_out  out  NUM_CH  generated clocks; registered.
- cyc_start  out  NUM_CH  one-cycle pulse at each period start.

Behaviour:
- Reset (async, active-high):
  - clk_out, cyc_start, cfg_err and cfg_pending all 0.
  - Shadow and active registers load DEF_*.
  - Every channel goes to IDLE.
- Channel FSM states: IDLE, PHASE, HIGH, LOW.
- Start: at edge k, en[i] is sampled 1 while the registered en_q[i] is 0 (or sync_start=1 with en[i]=1).
  - Active config loads from shadow; cfg_pending[i] clears.
  - Channel enters PHASE and counts Φ cycles.
  - First clk_out rise is at edge k+Φ+1, together with a cyc_start pulse.
- Steady run:
  - HIGH lasts H cycles, then LOW lasts P−H cycles, then back to HIGH.
  - Period = P cycles; cyc_start[i] pulses in the first HIGH cycle of every period.
  - Phase is applied only on a start, never on a reconfig.
- Degenerate settings:
  - H=0: clk_out stays 0, but cyc_start still pulses every P cycles.
  - H≥P: clk_out stays 1, and cyc_start pulses every P cycles.
  - P=1 with H≥1: output is constant 1.
- Config write (cfg_valid=1):
  - Writes shadow[cfg_ch] and sets cfg_pending.
  - Rejected, with a cfg_err pulse on the next cycle and no state change, if cfg_period=0 or cfg_ch≥NUM_CH.
  - A later write before the boundary overwrites the shadow; the last write wins.
- Reconfig apply: at the edge that would begin a new period, if cfg_pending=1, the active config loads from shadow and the new period uses it.
  - The current period always completes with the old values.
  - A write in the same cycle as a boundary is not applied until the following boundary.
- Disable: en[i] sampled 0 → channel returns to IDLE.
  - clk_out[i] is 0 from the next edge; any partial period is abandoned.
  - Shadow is retained.
- sync_start on a running channel: immediate restart as above, phase re-applied. Channels with en=0 ignore it.
- Simultaneous sync_start and a rising edge of en: treated as a single start.
- Counter widths: counters are CNT_W bits; comparisons are unsigned; no wrap occurs because every count is bounded by P or Φ.

Decomposition:
- Package clk_gen_pkg holds:
  - the chan_state_e enum (IDLE/PHASE/HIGH/LOW);
  - the struct chan_cfg_t {period, high, phase}, parametrised by CNT_W through a localparam default;
  - the function sanitising H versus P.
- Sub-module clk_gen_chan is a single channel: FSM, counter, shadow/active registers and pending flag.
- The top instantiates NUM_CH copies of clk_gen_chan and holds the config decode plus cfg_err generation.

Test Plan:
1. Reset defaults (P=4, H=2, Φ=0); raise en[0] at edge k → clk_out[0] is 1 at edges k+1 and k+2, 0 at k+3 and k+4; period 4; cyc_start[0] at k+1, k+5, …
2. Write ch1 with P=10, H=5, Φ=7, then raise en[1] at edge k → first rise at k+8; high 5, low 5; cyc_start[1] every 10 cycles.
3. Ch0 running at 4/2; write P=6, H=1 mid-period → cfg_pending[0]=1 and the current period finishes at 4/2; the next period is 6/1; pending clears at that boundary.
4. Ch2 with H=0 → clk_out[2] is constant 0 with cyc_start every P. Then P=10, H=12 → constant 1.
5. Reject cases: cfg_period=0, then cfg_ch=NUM_CH → each gives a cfg_err pulse one cycle later, with shadow and cfg_pending unchanged.
6. Ch0 with Φ=3 and ch1 with Φ=0 both running; pulse sync_start → ch1 rises 1 cycle later and ch0 4 cycles later. Then assert rst mid-HIGH → all clk_out drop to 0 asynchronously and stay IDLE after release until en is toggled.
